// File: rtl/exc_redirect_ctrl.sv
// Exception/ERET redirect controller.
// Consumes the exception/ERET indication retiring from WB, flushes pipes 1-3
// for FLUSH_CYCLES cycles, then offers the redirect PC to fetch under a
// valid/allow handshake. WB is held off for the whole sequence.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a retiring exception or ERET
// FLUSH    | flush asserted, counter running down to zero
// REDIRECT | redirect_pc offered to fetch, waiting for if_allow_in
module exc_redirect_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic        wb_is_exl,
    input  logic        wb_eret,
    input  logic [31:0] wb_epc,
    input  logic [4:0]  wb_cause,
    input  logic        if_allow_in,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        wb_block,
    output logic [15:0] exc_count,
    output logic [4:0]  last_cause
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Counter load value; a load of 0 gives exactly one flush cycle.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [2:0] flush_cnt;
    logic       trigger;

    assign trigger = wb_valid & (wb_is_exl | wb_eret);

    // Sequencer: state, flush counter, registered outputs and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            flush_cnt      <= 3'd0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            wb_block       <= 1'b0;
            exc_count      <= 16'd0;
            last_cause     <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                        flush     <= 1'b1;
                        wb_block  <= 1'b1;
                        // Exception wins when both indications are present.
                        if (wb_is_exl) begin
                            redirect_pc <= EXC_VECTOR;
                            last_cause  <= wb_cause;
                            if (exc_count != 16'hFFFF)
                                exc_count <= exc_count + 16'd1;
                        end else begin
                            redirect_pc <= wb_epc;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state          <= REDIRECT;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                REDIRECT: begin
                    // redirect_pc is left untouched so it stays stable and
                    // keeps its value after the handshake.
                    if (if_allow_in) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        wb_block       <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                    wb_block       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed testbench for exc_redirect_ctrl.
// A second instance with FLUSH_CYCLES=1 covers the short-flush and saturation case.
module tb_exc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_is_exl;
    logic        wb_eret;
    logic [31:0] wb_epc;
    logic [4:0]  wb_cause;
    logic        if_allow_in;

    logic        flush, redirect_valid, wb_block;
    logic [31:0] redirect_pc;
    logic [15:0] exc_count;
    logic [4:0]  last_cause;

    logic        flush1, redirect_valid1, wb_block1;
    logic [31:0] redirect_pc1;
    logic [15:0] exc_count1;
    logic [4:0]  last_cause1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exc_redirect_ctrl dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_is_exl(wb_is_exl),
        .wb_eret(wb_eret), .wb_epc(wb_epc), .wb_cause(wb_cause),
        .if_allow_in(if_allow_in), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .wb_block(wb_block), .exc_count(exc_count),
        .last_cause(last_cause)
    );

    exc_redirect_ctrl #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_is_exl(wb_is_exl),
        .wb_eret(wb_eret), .wb_epc(wb_epc), .wb_cause(wb_cause),
        .if_allow_in(if_allow_in), .flush(flush1), .redirect_valid(redirect_valid1),
        .redirect_pc(redirect_pc1), .wb_block(wb_block1), .exc_count(exc_count1),
        .last_cause(last_cause1)
    );

    // Advance one cycle; inputs are then changed and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid  = 1'b0;
        wb_is_exl = 1'b0;
        wb_eret   = 1'b0;
        wb_epc    = 32'd0;
        wb_cause  = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        if_allow_in = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({flush, redirect_valid, redirect_pc, wb_block, exc_count, last_cause} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got f=%b rv=%b pc=%h blk=%b cnt=%h cause=%0d, want all 0",
                     flush, redirect_valid, redirect_pc, wb_block, exc_count, last_cause);
        end
        rst = 1'b0;
        wb_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({flush, redirect_valid, redirect_pc, wb_block, exc_count, last_cause} !== 56'd0) begin
                n_fail++;
                $display("FAIL idle_no_trigger[%0d]: got f=%b rv=%b pc=%h blk=%b cnt=%h, want all 0",
                         i, flush, redirect_valid, redirect_pc, wb_block, exc_count);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_exception();
        if_allow_in = 1'b1;
        wb_valid  = 1'b1;
        wb_is_exl = 1'b1;
        wb_cause  = 5'd12;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) idle_inputs();
            n_checks++;
            if (flush !== (k <= 3) || redirect_valid !== (k == 4) || wb_block !== (k <= 4)) begin
                n_fail++;
                $display("FAIL exc_timing[T+%0d]: got f=%b rv=%b blk=%b, want f=%b rv=%b blk=%b",
                         k, flush, redirect_valid, wb_block, k <= 3, k == 4, k <= 4);
            end
            if (k == 4) begin
                n_checks++;
                if (redirect_pc !== 32'hBFC00380) begin
                    n_fail++;
                    $display("FAIL exc_pc: got %h, want bfc00380", redirect_pc);
                end
            end
        end
        n_checks++;
        if (exc_count !== 16'd1 || last_cause !== 5'd12) begin
            n_fail++;
            $display("FAIL exc_stats: got cnt=%0d cause=%0d, want cnt=1 cause=12", exc_count, last_cause);
        end
    endtask

    task automatic test_eret_stall();
        int rv_cycles = 0;
        if_allow_in = 1'b0;
        wb_valid = 1'b1;
        wb_eret  = 1'b1;
        wb_epc   = 32'h8000_1234;
        wb_cause = 5'd7;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) idle_inputs();
            if (k == 6) if_allow_in = 1'b1;
            if (redirect_valid) begin
                rv_cycles++;
                n_checks++;
                if (redirect_pc !== 32'h8000_1234) begin
                    n_fail++;
                    $display("FAIL eret_pc[T+%0d]: got %h, want 80001234", k, redirect_pc);
                end
            end
            n_checks++;
            if (redirect_valid !== (k >= 4 && k <= 6) || wb_block !== (k <= 6)) begin
                n_fail++;
                $display("FAIL eret_timing[T+%0d]: got rv=%b blk=%b, want rv=%b blk=%b",
                         k, redirect_valid, wb_block, k >= 4 && k <= 6, k <= 6);
            end
        end
        n_checks++;
        if (rv_cycles != 3) begin
            n_fail++;
            $display("FAIL eret_hold: got %0d valid cycles, want 3", rv_cycles);
        end
        n_checks++;
        if (exc_count !== 16'd1 || last_cause !== 5'd12) begin
            n_fail++;
            $display("FAIL eret_stats: got cnt=%0d cause=%0d, want cnt=1 cause=12", exc_count, last_cause);
        end
    endtask

    task automatic test_simultaneous();
        if_allow_in = 1'b1;
        wb_valid  = 1'b1;
        wb_is_exl = 1'b1;
        wb_eret   = 1'b1;
        wb_epc    = 32'h1000;
        wb_cause  = 5'd7;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                wb_eret  = 1'b0;
                wb_cause = 5'd4;
            end
            if (k == 2) idle_inputs();
            if (k == 4) begin
                n_checks++;
                if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC00380) begin
                    n_fail++;
                    $display("FAIL simul_pc: got rv=%b pc=%h, want rv=1 pc=bfc00380", redirect_valid, redirect_pc);
                end
            end
        end
        n_checks++;
        if (exc_count !== 16'd2 || last_cause !== 5'd7 || wb_block !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_stats: got cnt=%0d cause=%0d blk=%b f=%b, want cnt=2 cause=7 blk=0 f=0",
                     exc_count, last_cause, wb_block, flush);
        end
    endtask

    task automatic test_reset_mid();
        int seen_rv = 0;
        int lat = 0;
        if_allow_in = 1'b1;
        wb_valid  = 1'b1;
        wb_is_exl = 1'b1;
        wb_cause  = 5'd3;
        tick();
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({flush, redirect_valid, redirect_pc, wb_block, exc_count, last_cause} !== 56'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got f=%b rv=%b pc=%h blk=%b cnt=%h cause=%0d, want all 0",
                     flush, redirect_valid, redirect_pc, wb_block, exc_count, last_cause);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (redirect_valid || flush) seen_rv++;
        end
        n_checks++;
        if (seen_rv != 0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got %0d active cycles, want 0", seen_rv);
        end
        wb_valid  = 1'b1;
        wb_is_exl = 1'b1;
        wb_cause  = 5'd9;
        tick();
        idle_inputs();
        lat = 1;
        while (!redirect_valid && lat < 12) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat != 4 || redirect_pc !== 32'hBFC00380) begin
            n_fail++;
            $display("FAIL mid_reset_retry: got rv at T+%0d pc=%h, want T+4 pc=bfc00380", lat, redirect_pc);
        end
        n_checks++;
        if (exc_count !== 16'd1 || last_cause !== 5'd9) begin
            n_fail++;
            $display("FAIL mid_reset_stats: got cnt=%0d cause=%0d, want cnt=1 cause=9", exc_count, last_cause);
        end
        tick();
        tick();
    endtask

    task automatic test_param_saturation();
        int fcycles = 0;
        idle_inputs();
        if_allow_in = 1'b1;
        tick();
        tick();
        force dut1.exc_count = 16'hFFFE;
        #2;
        release dut1.exc_count;
        tick();
        wb_valid  = 1'b1;
        wb_is_exl = 1'b1;
        wb_cause  = 5'd2;
        tick();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            if (flush1) fcycles++;
            n_checks++;
            if (redirect_valid1 !== (k == 2) || (flush1 && redirect_valid1)) begin
                n_fail++;
                $display("FAIL fc1_timing[T+%0d]: got f=%b rv=%b, want f=%b rv=%b",
                         k, flush1, redirect_valid1, k == 1, k == 2);
            end
            if (k < 3) tick();
        end
        n_checks++;
        if (fcycles != 1) begin
            n_fail++;
            $display("FAIL fc1_flush_len: got %0d cycles, want 1", fcycles);
        end
        n_checks++;
        if (exc_count1 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_first: got cnt=%h, want ffff", exc_count1);
        end
        wb_valid  = 1'b1;
        wb_is_exl = 1'b1;
        wb_cause  = 5'd6;
        tick();
        idle_inputs();
        n_checks++;
        if (exc_count1 !== 16'hFFFF || last_cause1 !== 5'd6 || flush1 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_second: got cnt=%h cause=%0d f=%b, want cnt=ffff cause=6 f=1",
                     exc_count1, last_cause1, flush1);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_eret_stall();
        test_simultaneous();
        test_reset_mid();
        test_param_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
